// File: rtl/jtpopeye_prio_mix_if.sv
//------------------------------------------------------------------------------
// jtpopeye_prio_mix_if
// Pixel, palette-programming and fade bus of the priority mixer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface jtpopeye_prio_mix_if #(
    parameter int LAYERS = 3,
    parameter int AW     = 8
);
    logic                   pxl2_cen;
    logic [LAYERS-1:0]      gfx_en;
    logic [AW-1:0]          prog_addr;
    logic [1:0]             prog_layer;
    logic                   prog_we;
    logic [7:0]             prom_din;
    logic                   HBD_n;
    logic                   VB_n;
    logic [LAYERS*AW-1:0]   pxl_col;
    logic [LAYERS-1:0]      pxl_opaque;
    logic                   fade_req;
    logic                   fade_dir;
    logic                   fade_busy;
    logic [2:0]             red;
    logic [2:0]             green;
    logic [1:0]             blue;

    modport master (
        output pxl2_cen, gfx_en, prog_addr, prog_layer, prog_we, prom_din,
               HBD_n, VB_n, pxl_col, pxl_opaque, fade_req, fade_dir,
        input  fade_busy, red, green, blue
    );

    modport slave (
        input  pxl2_cen, gfx_en, prog_addr, prog_layer, prog_we, prom_din,
               HBD_n, VB_n, pxl_col, pxl_opaque, fade_req, fade_dir,
        output fade_busy, red, green, blue
    );
endinterface

`default_nettype wire

// File: rtl/jtpopeye_prio_mix.sv
//------------------------------------------------------------------------------
// jtpopeye_prio_mix
// Per-layer palette lookup, fixed priority mix (layer 0 on top), blanking and
// optional screen fade. Define JTPOPEYE_FADE_EN to build the fade FSM.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module jtpopeye_prio_mix #(
    parameter int LAYERS = 3,
    parameter int AW     = 8,
    parameter int INVERT = 1
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    jtpopeye_prio_mix_if.slave      bus
);

    // palette read data of all layers, layer n at [n*8 +: 8]
    logic [LAYERS*8-1:0] pal_bus;

    generate
        for (genvar n = 0; n < LAYERS; n++) begin : g_layer
            logic [7:0]    mem [0:(1<<AW)-1];
            logic [7:0]    rd_q;
            logic [AW-1:0] rd_addr;

            assign rd_addr = bus.pxl_col[n*AW +: AW];

            // palette write; prog_layer values beyond LAYERS-1 match no layer
            always_ff @(posedge clk) begin
                if (bus.prog_we && (bus.prog_layer == 2'(n)))
                    mem[bus.prog_addr] <= bus.prom_din;
            end

            // registered palette read (old data on a same-address write)
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    rd_q <= 8'd0;
                else if (bus.pxl2_cen)
                    rd_q <= mem[rd_addr];
            end

            assign pal_bus[n*8 +: 8] = rd_q;
        end
    endgenerate

    logic [LAYERS-1:0] sel_q;
    logic              blank_q;

    // stage 1: layer select and blanking flags alongside the palette read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= '0;
            blank_q <= 1'b0;
        end else if (bus.pxl2_cen) begin
            sel_q   <= bus.pxl_opaque & bus.gfx_en;
            blank_q <= !bus.HBD_n | !bus.VB_n;
        end
    end

    // brightness level: 7 = full, 0 = black
    logic [2:0] level;
    logic       busy_q;

`ifdef JTPOPEYE_FADE_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OUT  = 2'd1,
        ST_IN   = 2'd2
    } state_t;

    state_t state;
    logic   vb_last;
    logic   vb_fall;

    assign vb_fall = vb_last & ~bus.VB_n;

    // fade FSM: one brightness step per VB_n falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            level   <= 3'd7;
            busy_q  <= 1'b0;
            vb_last <= 1'b1;
        end else begin
            vb_last <= bus.VB_n;
            case (state)
                ST_IDLE: begin
                    // a coincident VB_n edge only starts the fade, no step yet
                    if (bus.fade_req) begin
                        state  <= bus.fade_dir ? ST_OUT : ST_IN;
                        busy_q <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (vb_fall) begin
                        if (level != 3'd0)
                            level <= level - 3'd1;
                        if (level <= 3'd1) begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                ST_IN: begin
                    if (vb_fall) begin
                        if (level != 3'd7)
                            level <= level + 3'd1;
                        if (level >= 3'd6) begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_fade;

    assign level       = 3'd7;
    assign busy_q      = 1'b0;
    assign unused_fade = bus.fade_req ^ bus.fade_dir;
`endif

    assign bus.fade_busy = busy_q;

    logic [7:0] pick;
    logic [2:0] dim;
    logic [2:0] r_next;
    logic [2:0] g_next;
    logic [1:0] b_next;

    // priority pick (lowest index wins) and fade subtraction
    always_comb begin
        pick = 8'd0;
        for (int i = LAYERS-1; i >= 0; i--) begin
            if (sel_q[i])
                pick = (INVERT != 0) ? ~pal_bus[i*8 +: 8] : pal_bus[i*8 +: 8];
        end
        if (blank_q)
            pick = 8'd0;
        dim    = 3'd7 - level;
        r_next = (pick[2:0] > dim) ? (pick[2:0] - dim) : 3'd0;
        g_next = (pick[5:3] > dim) ? (pick[5:3] - dim) : 3'd0;
        b_next = (pick[7:6] > dim[2:1]) ? (pick[7:6] - dim[2:1]) : 2'd0;
    end

    logic [2:0] red_q;
    logic [2:0] green_q;
    logic [1:0] blue_q;

    // stage 2: registered RGB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_q   <= 3'd0;
            green_q <= 3'd0;
            blue_q  <= 2'd0;
        end else if (bus.pxl2_cen) begin
            red_q   <= r_next;
            green_q <= g_next;
            blue_q  <= b_next;
        end
    end

    assign bus.red   = red_q;
    assign bus.green = green_q;
    assign bus.blue  = blue_q;

endmodule

`default_nettype wire
